// File: rtl/math_acc_pkg.sv
// Shared types, defaults and width helpers for the math result accumulator.
// DATASIZE sets the computer's data width; results carry one extra bit.
`ifndef DATASIZE
`define DATASIZE 16
`endif

package math_acc_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } acc_state_t;

  localparam int MIN_BLOCK_LEN = 2;
  localparam int DEF_RES_W     = `DATASIZE + 1;

  // One extra bit of headroom above the worst-case block sum.
  function automatic int sum_width(input int res_w, input int block_len);
    return res_w + $clog2(block_len) + 1;
  endfunction

endpackage

// File: rtl/math_result_accumulator_if.sv
// Result-in / record-out stream bundle for math_result_accumulator.
// MATH_ACC_MIN_EN adds the out_min record field.
interface math_result_accumulator_if
  import math_acc_pkg::*;
#(
  parameter int RES_W     = DEF_RES_W,
  parameter int BLOCK_LEN = 8
);
  localparam int SUM_W = sum_width(RES_W, BLOCK_LEN);
  localparam int CNT_W = $clog2(BLOCK_LEN) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] in_result;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [RES_W-1:0] out_max;
  logic [CNT_W-1:0] out_count;
`ifdef MATH_ACC_MIN_EN
  logic [RES_W-1:0] out_min;
`endif

  modport slave (
    input  in_valid, in_result, flush, out_ready,
    output in_ready, out_valid, out_sum, out_max, out_count
`ifdef MATH_ACC_MIN_EN
    , output out_min
`endif
  );

  modport master (
    output in_valid, in_result, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_max, out_count
`ifdef MATH_ACC_MIN_EN
    , input out_min
`endif
  );

endinterface

// File: rtl/math_result_fifo.sv
// Small synchronous FIFO with show-ahead read; full/empty come from a registered
// occupancy count, so a full FIFO never accepts a push even when popping.
module math_result_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/math_result_accumulator.sv
// Buffers math results and reduces them in blocks of BLOCK_LEN into {sum,max,count}
// records. Defining MATH_ACC_MIN_EN also tracks the block minimum on out_min.
module math_result_accumulator
  import math_acc_pkg::*;
#(
  parameter int RES_W      = DEF_RES_W,
  parameter int BLOCK_LEN  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  math_result_accumulator_if.slave bus
);
  localparam int SUM_W = sum_width(RES_W, BLOCK_LEN);
  localparam int CNT_W = $clog2(BLOCK_LEN) + 1;

  acc_state_t       state_reg, state_next;
  logic [SUM_W-1:0] acc_sum_reg, acc_sum_next, out_sum_reg, out_sum_next;
  logic [RES_W-1:0] acc_max_reg, acc_max_next, out_max_reg, out_max_next;
  logic [CNT_W-1:0] acc_cnt_reg, acc_cnt_next, out_cnt_reg, out_cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic [RES_W-1:0] fifo_data;
  logic             fifo_full, fifo_empty, pop;
  logic [SUM_W-1:0] pop_sum;
  logic [RES_W-1:0] pop_max;
  logic [CNT_W-1:0] pop_cnt;

  math_result_fifo #(.WIDTH(RES_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (bus.in_valid),
    .push_data(bus.in_result),
    .pop      (pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Accumulator values as they would be after popping the FIFO head this cycle.
  assign pop_sum = acc_sum_reg + SUM_W'(fifo_data);
  assign pop_max = (acc_cnt_reg == '0 || fifo_data > acc_max_reg) ? fifo_data : acc_max_reg;
  assign pop_cnt = acc_cnt_reg + CNT_W'(1);

`ifdef MATH_ACC_MIN_EN
  logic [RES_W-1:0] acc_min_reg, acc_min_next, out_min_reg, out_min_next, pop_min;
  assign pop_min = (acc_cnt_reg == '0 || fifo_data < acc_min_reg) ? fifo_data : acc_min_reg;
  assign bus.out_min = out_min_reg;
`endif

  always_comb begin
    state_next     = state_reg;
    acc_sum_next   = acc_sum_reg;
    acc_max_next   = acc_max_reg;
    acc_cnt_next   = acc_cnt_reg;
    out_sum_next   = out_sum_reg;
    out_max_next   = out_max_reg;
    out_cnt_next   = out_cnt_reg;
    out_valid_next = out_valid_reg;
    pop            = 1'b0;
`ifdef MATH_ACC_MIN_EN
    acc_min_next   = acc_min_reg;
    out_min_next   = out_min_reg;
`endif
    case (state_reg)
      ACCUM: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (pop_cnt == CNT_W'(BLOCK_LEN) || bus.flush) begin
            out_sum_next   = pop_sum;
            out_max_next   = pop_max;
            out_cnt_next   = pop_cnt;
            out_valid_next = 1'b1;
            acc_sum_next   = '0;
            acc_max_next   = '0;
            acc_cnt_next   = '0;
`ifdef MATH_ACC_MIN_EN
            out_min_next   = pop_min;
            acc_min_next   = '0;
`endif
            state_next     = EMIT;
          end else begin
            acc_sum_next = pop_sum;
            acc_max_next = pop_max;
            acc_cnt_next = pop_cnt;
`ifdef MATH_ACC_MIN_EN
            acc_min_next = pop_min;
`endif
          end
        end else if (bus.flush && acc_cnt_reg != '0) begin
          out_sum_next   = acc_sum_reg;
          out_max_next   = acc_max_reg;
          out_cnt_next   = acc_cnt_reg;
          out_valid_next = 1'b1;
          acc_sum_next   = '0;
          acc_max_next   = '0;
          acc_cnt_next   = '0;
`ifdef MATH_ACC_MIN_EN
          out_min_next   = acc_min_reg;
          acc_min_next   = '0;
`endif
          state_next     = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          out_sum_next   = '0;
          out_max_next   = '0;
          out_cnt_next   = '0;
          out_valid_next = 1'b0;
`ifdef MATH_ACC_MIN_EN
          out_min_next   = '0;
`endif
          state_next     = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ACCUM;
      acc_sum_reg   <= '0;
      acc_max_reg   <= '0;
      acc_cnt_reg   <= '0;
      out_sum_reg   <= '0;
      out_max_reg   <= '0;
      out_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
`ifdef MATH_ACC_MIN_EN
      acc_min_reg   <= '0;
      out_min_reg   <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      acc_sum_reg   <= acc_sum_next;
      acc_max_reg   <= acc_max_next;
      acc_cnt_reg   <= acc_cnt_next;
      out_sum_reg   <= out_sum_next;
      out_max_reg   <= out_max_next;
      out_cnt_reg   <= out_cnt_next;
      out_valid_reg <= out_valid_next;
`ifdef MATH_ACC_MIN_EN
      acc_min_reg   <= acc_min_next;
      out_min_reg   <= out_min_next;
`endif
    end
  end

  assign bus.in_ready  = !fifo_full;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = out_sum_reg;
  assign bus.out_max   = out_max_reg;
  assign bus.out_count = out_cnt_reg;

endmodule

// File: tb/tb_math_result_accumulator.sv
// Self-checking bench for math_result_accumulator: directed vector table, corner
// sequences (stall/backpressure, reset in EMIT) and a randomized scoreboard run.
module tb_math_result_accumulator;
  import math_acc_pkg::*;

  localparam int RES_W = DEF_RES_W;
  localparam int BL    = 8;
  localparam int FD    = 4;
  localparam int SUM_W = sum_width(RES_W, BL);
  localparam int CNT_W = $clog2(BL) + 1;
  localparam longint MAXV = (longint'(1) << RES_W) - 1;

  typedef struct {
    int                      n;
    bit                      fl;
    logic [7:0][RES_W-1:0]   vals;
    longint                  e_sum;
    longint                  e_max;
    longint                  e_min;
    int                      e_cnt;
  } vec_t;

  typedef struct {
    longint sum;
    longint max;
    longint min;
    int     cnt;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  math_result_accumulator_if #(.RES_W(RES_W), .BLOCK_LEN(BL)) bus ();

  math_result_accumulator #(.RES_W(RES_W), .BLOCK_LEN(BL), .FIFO_DEPTH(FD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_val(input logic [RES_W-1:0] v);
    int t = 0;
    bus.in_valid  = 1'b1;
    bus.in_result = v;
    while (!bus.in_ready && t < 100) begin
      tick();
      t++;
    end
    if (!bus.in_ready) timeout("push");
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_record(output bit ok);
    int t = 0;
    while (!bus.out_valid && t < 100) begin
      tick();
      t++;
    end
    ok = bus.out_valid;
    if (!ok) timeout("record_wait");
  endtask

  task automatic accept_record();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic check_record(input string tag, input rec_t e);
    check({tag, "_sum"}, 64'(bus.out_sum), 64'(e.sum));
    check({tag, "_max"}, 64'(bus.out_max), 64'(e.max));
    check({tag, "_count"}, 64'(bus.out_count), 64'(e.cnt));
`ifdef MATH_ACC_MIN_EN
    check({tag, "_min"}, 64'(bus.out_min), 64'(e.min));
`endif
    $display("[TB] %s record sum=%0d max=%0d count=%0d", tag, bus.out_sum, bus.out_max, bus.out_count);
  endtask

  function automatic rec_t reduce(input longint q[$]);
    rec_t r;
    r.sum = 0;
    r.max = q[0];
    r.min = q[0];
    r.cnt = q.size();
    foreach (q[i]) begin
      r.sum += q[i];
      if (q[i] > r.max) r.max = q[i];
      if (q[i] < r.min) r.min = q[i];
    end
    return r;
  endfunction

  vec_t vt[6];

  initial begin
    bit     ok;
    rec_t   e;
    longint blk[$];
    rec_t   exp_q[$];
    int     hi_cnt;
    int     accepted;
    bit     stable;
    longint held_sum;

    bus.in_valid  = 1'b0;
    bus.in_result = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    vt[0] = '{n: 8, fl: 1'b0, vals: '0, e_sum: 36, e_max: 8, e_min: 1, e_cnt: 8};
    for (int j = 0; j < 8; j++) vt[0].vals[j] = RES_W'(j + 1);
    vt[1] = '{n: 3, fl: 1'b1, vals: '0, e_sum: 17, e_max: 9, e_min: 3, e_cnt: 3};
    vt[1].vals[0] = 5; vt[1].vals[1] = 9; vt[1].vals[2] = 3;
    vt[2] = '{n: 8, fl: 1'b0, vals: '0, e_sum: 8 * MAXV, e_max: MAXV, e_min: MAXV, e_cnt: 8};
    for (int j = 0; j < 8; j++) vt[2].vals[j] = RES_W'(MAXV);
    vt[3] = '{n: 1, fl: 1'b1, vals: '0, e_sum: 42, e_max: 42, e_min: 42, e_cnt: 1};
    vt[3].vals[0] = 42;
    vt[4] = '{n: 3, fl: 1'b1, vals: '0, e_sum: 18, e_max: 9, e_min: 2, e_cnt: 3};
    vt[4].vals[0] = 7; vt[4].vals[1] = 2; vt[4].vals[2] = 9;
    vt[5] = '{n: 8, fl: 1'b0, vals: '0, e_sum: 280, e_max: 70, e_min: 0, e_cnt: 8};
    vt[5].vals[0] = 10; vt[5].vals[1] = 20; vt[5].vals[2] = 0;  vt[5].vals[3] = 70;
    vt[5].vals[4] = 30; vt[5].vals[5] = 60; vt[5].vals[6] = 40; vt[5].vals[7] = 50;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_sum", 64'(bus.out_sum), 64'd0);
    check("reset_out_max", 64'(bus.out_max), 64'd0);
    check("reset_out_count", 64'(bus.out_count), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vt[i].n; j++) push_val(vt[i].vals[j]);
      if (vt[i].fl) begin
        repeat (BL + 2) tick();
        pulse_flush();
      end
      wait_record(ok);
      if (ok) begin
        e = '{sum: vt[i].e_sum, max: vt[i].e_max, min: vt[i].e_min, cnt: vt[i].e_cnt};
        check_record($sformatf("vec%0d", i), e);
        accept_record();
        check($sformatf("vec%0d_cleared_valid", i), 64'(bus.out_valid), 64'd0);
        check($sformatf("vec%0d_cleared_sum", i), 64'(bus.out_sum), 64'd0);
      end
    end

    // Flush with nothing accumulated must not produce a record
    pulse_flush();
    repeat (3) tick();
    check("empty_flush_ignored", 64'(bus.out_valid), 64'd0);

    // out_valid lasts one cycle with out_ready held high
    bus.out_ready = 1'b1;
    for (int j = 1; j <= 8; j++) push_val(RES_W'(j));
    hi_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.out_valid) hi_cnt++;
    end
    bus.out_ready = 1'b0;
    check("valid_one_cycle", 64'(hi_cnt), 64'd1);

    // Backpressure: 12 results offered, record held, FIFO fills
    accepted = 0;
    stable   = 1'b1;
    held_sum = -1;
    for (int c = 0; c < 20; c++) begin
      bus.in_valid  = (accepted < 12);
      bus.in_result = RES_W'(accepted + 1);
      ok = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        if (held_sum < 0) held_sum = longint'(bus.out_sum);
        else if (longint'(bus.out_sum) != held_sum) stable = 1'b0;
      end
      tick();
      if (ok) accepted++;
    end
    bus.in_valid = 1'b0;
    check("stall_accepted", 64'(accepted), 64'd12);
    check("stall_in_ready_low", 64'(bus.in_ready), 64'd0);
    check("stall_record_stable", 64'(stable), 64'd1);
    e = '{sum: 36, max: 8, min: 1, cnt: 8};
    check_record("stall_first", e);
    accept_record();
    repeat (8) tick();
    pulse_flush();
    wait_record(ok);
    if (ok) begin
      e = '{sum: 42, max: 12, min: 9, cnt: 4};
      check_record("stall_rest", e);
      accept_record();
    end

    // Reset while in EMIT with entries queued
    for (int j = 1; j <= 11; j++) push_val(RES_W'(j));
    tick();
    check("emit_before_reset", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_emit_valid", 64'(bus.out_valid), 64'd0);
    check("rst_emit_sum", 64'(bus.out_sum), 64'd0);
    check("rst_emit_max", 64'(bus.out_max), 64'd0);
    check("rst_emit_count", 64'(bus.out_count), 64'd0);
    check("rst_emit_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (6) tick();
    pulse_flush();
    repeat (3) tick();
    check("rst_fifo_empty", 64'(bus.out_valid), 64'd0);

    // Randomized run against a block-reduction scoreboard
    begin
      bit     fire_in, fire_out, hold;
      rec_t   got, prev;
      longint v;
      hold = 1'b0;
      prev = '{sum: 0, max: 0, min: 0, cnt: 0};
      for (int c = 0; c < 600; c++) begin
        got.sum = longint'(bus.out_sum);
        got.max = longint'(bus.out_max);
        got.cnt = int'(bus.out_count);
`ifdef MATH_ACC_MIN_EN
        got.min = longint'(bus.out_min);
`else
        got.min = 0;
`endif
        if (hold) begin
          check("rand_hold_valid", 64'(bus.out_valid), 64'd1);
          check("rand_hold_sum", 64'(got.sum), 64'(prev.sum));
        end
        v = ($urandom_range(0, 7) == 0) ? MAXV : longint'($urandom_range(0, 1000));
        bus.in_valid  = (c < 560) && ($urandom_range(0, 3) != 0);
        bus.in_result = RES_W'(v);
        bus.out_ready = (c >= 560) || ($urandom_range(0, 1) == 1);
        fire_in  = bus.in_valid && bus.in_ready;
        fire_out = bus.out_valid && bus.out_ready;
        hold     = bus.out_valid && !bus.out_ready;
        prev     = got;
        if (fire_out) begin
          if (exp_q.size() == 0) begin
            timeout("rand_unexpected_record");
          end else begin
            e = exp_q.pop_front();
            check("rand_sum", 64'(got.sum), 64'(e.sum));
            check("rand_max", 64'(got.max), 64'(e.max));
            check("rand_count", 64'(got.cnt), 64'(e.cnt));
`ifdef MATH_ACC_MIN_EN
            check("rand_min", 64'(got.min), 64'(e.min));
`endif
            $display("[TB] rand record sum=%0d max=%0d count=%0d", got.sum, got.max, got.cnt);
          end
        end
        if (fire_in) begin
          blk.push_back(v);
          if (blk.size() == BL) begin
            exp_q.push_back(reduce(blk));
            blk.delete();
          end
        end
        tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("rand_all_records_seen", 64'(exp_q.size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
